// File: rtl/sass_audio_pkg.sv
// Shared audio-path constants and types for the lookup, oscillator and mixer.
package sass_audio_pkg;

   localparam int DIV_W   = 19;
   localparam int MIN_DIV = 2;

   // Lookup code that requests silence.
   localparam logic [DIV_W-1:0] DIV_OFF = 19'd1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } tone_state_t;

endpackage

// File: rtl/tone_period_cnt.sv
// Period counter for tone_osc: holds the active divider and position in the period.
// Exposes next-state values so the owner can register outputs that track the counter.
module tone_period_cnt #(
   parameter int DIV_W = sass_audio_pkg::DIV_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [DIV_W-1:0] load_div,
   input  logic             inc,
   input  logic             clr,
   output logic             wrap,
   output logic [DIV_W-1:0] count_nxt,
   output logic [DIV_W-1:0] div_nxt
);

   logic [DIV_W-1:0] count;
   logic [DIV_W-1:0] cur_div;

   always_comb begin
      count_nxt = count;
      div_nxt   = cur_div;
      if (load) begin
         count_nxt = '0;
         div_nxt   = load_div;
      end else if (clr) begin
         count_nxt = '0;
      end else if (inc) begin
         count_nxt = count + DIV_W'(1);
      end
   end

   // Only meaningful while running, where cur_div is at least 2.
   assign wrap = (count == cur_div - DIV_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= '0;
         cur_div <= '0;
      end else begin
         count   <= count_nxt;
         cur_div <= div_nxt;
      end
   end

endmodule

// File: rtl/tone_osc.sv
// Square-wave tone oscillator: turns a full-period divider into a glitch-free
// square wave, switching pitch or going silent only at period boundaries.
//
//   state | meaning
//   IDLE  | silent, waiting for en with a playable divider
//   RUN   | generating tone; divider resampled at each wrap
module tone_osc
   import sass_audio_pkg::*;
#(
   parameter int DIV_W   = sass_audio_pkg::DIV_W,
   parameter int MIN_DIV = sass_audio_pkg::MIN_DIV
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [DIV_W-1:0] divider,
   output logic             square_out,
   output logic             period_tick,
   output logic             active
);

   localparam logic [DIV_W-1:0] MIN_D = DIV_W'(MIN_DIV);

   tone_state_t      state;
   tone_state_t      state_nxt;
   logic             div_ok;
   logic             load;
   logic             inc;
   logic             clr;
   logic             wrap;
   logic             tick_nxt;
   logic             sq_nxt;
   logic [DIV_W-1:0] count_nxt;
   logic [DIV_W-1:0] div_nxt;

   assign div_ok = (divider >= MIN_D);

   tone_period_cnt #(
      .DIV_W (DIV_W)
   ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_div  (divider),
      .inc       (inc),
      .clr       (clr),
      .wrap      (wrap),
      .count_nxt (count_nxt),
      .div_nxt   (div_nxt)
   );

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      inc       = 1'b0;
      clr       = 1'b0;
      tick_nxt  = 1'b0;
      if (en) begin
         case (state)
            IDLE: begin
               if (div_ok) begin
                  load      = 1'b1;
                  state_nxt = RUN;
               end
            end
            RUN: begin
               if (!wrap) begin
                  inc = 1'b1;
               end else if (div_ok) begin
                  load     = 1'b1;
                  tick_nxt = 1'b1;
               end else begin
                  clr       = 1'b1;
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Wave level follows the counter value being loaded this edge, so the
   // registered output lines up with the count it describes.
   assign sq_nxt = (state_nxt == RUN) && (count_nxt < (div_nxt >> 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         square_out  <= 1'b0;
         period_tick <= 1'b0;
         active      <= 1'b0;
      end else begin
         state       <= state_nxt;
         square_out  <= sq_nxt;
         period_tick <= tick_nxt;
         active      <= (state_nxt == RUN);
      end
   end

endmodule
